// File: rtl/hazard_ctrl.sv
// Hazard and sequencing control for the 3-stage RV32I pipeline (D/X/W).
// Handles forwarding, load-use stalls, redirect squash and retire/cycle counters.
module hazard_ctrl #(
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic [31:0]      inst_d,
    input  logic             br_taken_x,
    input  logic             cnt_clr,
    output logic             stall,
    output logic             pc_redirect,
    output logic             d_kill,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             x_valid,
    output logic             w_valid,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IARI   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3;
    logic       use1, use2, wen;
    logic       unused_hi;

    assign op        = inst_d[6:0];
    assign rd        = inst_d[11:7];
    assign f3        = inst_d[14:12];
    assign rs1       = inst_d[19:15];
    assign rs2       = inst_d[24:20];
    assign unused_hi = ^inst_d[31:25];

    logic       d_vq;
    logic       x_v, x_wen, x_ld;
    logic [4:0] x_rd;
    logic [6:0] x_op;
    logic       w_v, w_wen;
    logic [4:0] w_rd;

    logic redir, haz;
    logic mxa, mxb, mwa, mwb;

    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        wen  = 1'b0;
        unique case (op)
            OPC_R:      begin use1 = 1'b1; use2 = 1'b1; wen = 1'b1; end
            OPC_IARI:   begin use1 = 1'b1; wen = 1'b1; end
            OPC_LOAD:   begin use1 = 1'b1; wen = 1'b1; end
            OPC_STORE:  begin use1 = 1'b1; use2 = 1'b1; end
            OPC_BRANCH: begin use1 = 1'b1; use2 = 1'b1; end
            OPC_JALR:   begin use1 = 1'b1; wen = 1'b1; end
            OPC_LUI:    wen = 1'b1;
            OPC_AUIPC:  wen = 1'b1;
            OPC_JAL:    wen = 1'b1;
            OPC_SYSTEM: use1 = (f3 == 3'b001);
            default:    ;
        endcase
    end

    // x0 never matches: it is hardwired and must not trigger forwarding or stalls
    assign mxa = x_v & x_wen & (x_rd != 5'd0) & (x_rd == rs1);
    assign mxb = x_v & x_wen & (x_rd != 5'd0) & (x_rd == rs2);
    assign mwa = w_v & w_wen & (w_rd != 5'd0) & (w_rd == rs1);
    assign mwb = w_v & w_wen & (w_rd != 5'd0) & (w_rd == rs2);

    always_comb begin
        redir     = x_v & ((x_op == OPC_JAL) | (x_op == OPC_JALR) |
                           ((x_op == OPC_BRANCH) & br_taken_x));
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (FWD_EN != 0) begin
            if (mxa & !x_ld)      fwd_a_sel = 2'b01;
            else if (mwa & !mxa)  fwd_a_sel = 2'b10;
            if (mxb & !x_ld)      fwd_b_sel = 2'b01;
            else if (mwb & !mxb)  fwd_b_sel = 2'b10;
            haz = (use1 & mxa & x_ld) | (use2 & mxb & x_ld);
        end else begin
            haz = (use1 & (mxa | mwa)) | (use2 & (mxb | mwb));
        end
        stall       = d_vq & !redir & haz;
        pc_redirect = redir & !hold;
        d_kill      = !d_vq | redir;
    end

    assign x_valid = x_v;
    assign w_valid = w_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_vq  <= 1'b1;
            x_v   <= 1'b0;
            x_rd  <= 5'd0;
            x_wen <= 1'b0;
            x_ld  <= 1'b0;
            x_op  <= 7'd0;
            w_v   <= 1'b0;
            w_rd  <= 5'd0;
            w_wen <= 1'b0;
        end else if (!hold) begin
            if (redir)      d_vq <= 1'b0;
            else if (!stall) d_vq <= 1'b1;
            if (stall | d_kill) begin
                x_v   <= 1'b0;
                x_rd  <= 5'd0;
                x_wen <= 1'b0;
                x_ld  <= 1'b0;
                x_op  <= 7'd0;
            end else begin
                x_v   <= 1'b1;
                x_rd  <= rd;
                x_wen <= wen;
                x_ld  <= (op == OPC_LOAD);
                x_op  <= op;
            end
            w_v   <= x_v;
            w_rd  <= x_rd;
            w_wen <= x_wen;
        end
    end

    // cycle_cnt keeps running through hold; clear beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            if (cnt_clr) cycle_cnt <= '0;
            else         cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (cnt_clr)          inst_cnt <= '0;
            else if (w_v & !hold) inst_cnt <= inst_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, redirect, hold, reset, counters.
// Second instance runs FWD_EN=0 with a 3-bit counter to reach the wrap boundary.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic [31:0] inst_d = 32'h13;
    logic        br_taken_x = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        stall, pc_redirect, d_kill, x_valid, w_valid;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] cycle_cnt, inst_cnt;

    logic        u_stall, u_pc_redirect, u_d_kill, u_x_valid, u_w_valid;
    logic [1:0]  u_fwd_a_sel, u_fwd_b_sel;
    logic [2:0]  u_cycle_cnt, u_inst_cnt;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = {7'd0, 5'd0, 5'd0, 3'd0, 5'd0, 7'b1100011};
    localparam logic [31:0] JAL0 = {20'd0, 5'd0, 7'b1101111};

    hazard_ctrl #(.FWD_EN(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .hold(hold), .inst_d(inst_d),
        .br_taken_x(br_taken_x), .cnt_clr(cnt_clr),
        .stall(stall), .pc_redirect(pc_redirect), .d_kill(d_kill),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .x_valid(x_valid), .w_valid(w_valid),
        .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
    );

    hazard_ctrl #(.FWD_EN(0), .CNT_W(3)) dut_nf (
        .clk(clk), .rst(rst), .hold(hold), .inst_d(inst_d),
        .br_taken_x(br_taken_x), .cnt_clr(cnt_clr),
        .stall(u_stall), .pc_redirect(u_pc_redirect), .d_kill(u_d_kill),
        .fwd_a_sel(u_fwd_a_sel), .fwd_b_sel(u_fwd_b_sel),
        .x_valid(u_x_valid), .w_valid(u_w_valid),
        .cycle_cnt(u_cycle_cnt), .inst_cnt(u_inst_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_add(input logic [4:0] rd,
                                          input logic [4:0] a,
                                          input logic [4:0] b);
        return {7'd0, b, a, 3'd0, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_addi(input logic [4:0] rd,
                                           input logic [4:0] a,
                                           input logic [11:0] imm);
        return {imm, a, 3'd0, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] i_lw(input logic [4:0] rd,
                                         input logic [4:0] a);
        return {12'd0, a, 3'b010, rd, 7'b0000011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1;
        hold = 1'b0;
        br_taken_x = 1'b0;
        cnt_clr = 1'b0;
        inst_d = NOP;
        #1;
        chk("rst_cyc", cycle_cnt, 0);
        chk("rst_inst", inst_cnt, 0);
        chk("rst_xv", x_valid, 0);
        chk("rst_wv", w_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_redir", pc_redirect, 0);
        chk("rst_kill", d_kill, 0);
        chk("rst_fa", fwd_a_sel, 0);
        chk("rst_fb", fwd_b_sel, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_rst();

        // addi x1 then dependent add: X forward on both operands
        inst_d = i_addi(5'd1, 5'd0, 12'd5);
        nxt();
        inst_d = r_add(5'd2, 5'd1, 5'd1);
        #1;
        chk("t1_fa", fwd_a_sel, 2'b01);
        chk("t1_fb", fwd_b_sel, 2'b01);
        chk("t1_stall", stall, 0);
        chk("t1_xv", x_valid, 1);
        chk("t1nf_stall0", u_stall, 1);
        chk("t1nf_fa", u_fwd_a_sel, 0);
        nxt();
        #1;
        chk("t1nf_stall1", u_stall, 1);
        chk("t1nf_xv", u_x_valid, 0);
        nxt();
        #1;
        chk("t1nf_stall2", u_stall, 0);

        // load-use: one stall, bubble, then W forward
        do_rst();
        inst_d = i_lw(5'd5, 5'd0);
        nxt();
        inst_d = r_add(5'd6, 5'd5, 5'd0);
        #1;
        chk("t2_stall", stall, 1);
        chk("t2_fa0", fwd_a_sel, 0);
        nxt();
        #1;
        chk("t2_stall1", stall, 0);
        chk("t2_xv", x_valid, 0);
        chk("t2_wv", w_valid, 1);
        chk("t2_fa", fwd_a_sel, 2'b10);
        chk("t2_fb", fwd_b_sel, 0);

        // writes to x0 never forward or stall
        do_rst();
        inst_d = i_addi(5'd0, 5'd0, 12'd1);
        nxt();
        inst_d = r_add(5'd3, 5'd0, 5'd0);
        #1;
        chk("t3_fa", fwd_a_sel, 0);
        chk("t3_fb", fwd_b_sel, 0);
        chk("t3_stall", stall, 0);
        chk("t3nf_stall", u_stall, 0);

        // taken branch: one redirect, two killed slots, only beq retires
        do_rst();
        inst_d = BEQ;
        nxt();
        inst_d = i_addi(5'd7, 5'd0, 12'd1);
        br_taken_x = 1'b1;
        #1;
        chk("t4_redir", pc_redirect, 1);
        chk("t4_kill0", d_kill, 1);
        chk("t4_stall", stall, 0);
        nxt();
        br_taken_x = 1'b0;
        inst_d = i_addi(5'd8, 5'd0, 12'd2);
        #1;
        chk("t4_redir1", pc_redirect, 0);
        chk("t4_kill1", d_kill, 1);
        chk("t4_xv1", x_valid, 0);
        chk("t4_wv1", w_valid, 1);
        nxt();
        inst_d = i_addi(5'd9, 5'd0, 12'd3);
        #1;
        chk("t4_kill2", d_kill, 0);
        chk("t4_wv2", w_valid, 0);
        chk("t4_ic2", inst_cnt, 1);
        nxt();
        #1;
        chk("t4_wv3", w_valid, 0);
        chk("t4_xv3", x_valid, 1);
        chk("t4_ic3", inst_cnt, 1);
        chk("t4_cc3", cycle_cnt, 4);

        // jal in X wins over a pending RAW stall (FWD_EN=0 instance)
        do_rst();
        inst_d = i_lw(5'd5, 5'd0);
        nxt();
        inst_d = JAL0;
        nxt();
        inst_d = r_add(5'd6, 5'd5, 5'd0);
        #1;
        chk("t5nf_stall", u_stall, 0);
        chk("t5nf_redir", u_pc_redirect, 1);
        chk("t5nf_kill", u_d_kill, 1);
        chk("t5_redir", pc_redirect, 1);
        nxt();
        #1;
        chk("t5nf_xv", u_x_valid, 0);
        chk("t5_xv", x_valid, 0);

        // hold for 5 cycles in the middle of a load-use stall
        do_rst();
        nxt();
        inst_d = i_lw(5'd5, 5'd0);
        nxt();
        inst_d = r_add(5'd6, 5'd5, 5'd0);
        hold = 1'b1;
        #1;
        chk("t6_stall", stall, 1);
        chk("t6_hredir", pc_redirect, 0);
        chk("t6_ic0", inst_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            nxt();
            #1;
            chk("t6_hstall", stall, 1);
            chk("t6_hxv", x_valid, 1);
            chk("t6_hwv", w_valid, 1);
            chk("t6_hfa", fwd_a_sel, 0);
        end
        chk("t6_cc", cycle_cnt, 7);
        chk("t6_ic", inst_cnt, 0);
        chk("t6nf_cc7", u_cycle_cnt, 7);
        hold = 1'b0;
        nxt();
        #1;
        chk("t6_ic1", inst_cnt, 1);
        chk("t6_stall1", stall, 0);
        chk("t6_xv1", x_valid, 0);
        chk("t6_fa", fwd_a_sel, 2'b10);
        chk("t6nf_wrap", u_cycle_cnt, 0);
        inst_d = NOP;
        nxt();
        #1;
        chk("t6_xv2", x_valid, 1);
        chk("t6_ic2", inst_cnt, 2);

        // reset pulse mid-run, then counter clear
        do_rst();
        nxt();
        nxt();
        nxt();
        #1;
        chk("t7_cc", cycle_cnt, 3);
        chk("t7_ic", inst_cnt, 1);
        cnt_clr = 1'b1;
        nxt();
        cnt_clr = 1'b0;
        #1;
        chk("t7_cc_clr", cycle_cnt, 0);
        chk("t7_ic_clr", inst_cnt, 0);
        nxt();
        #1;
        chk("t7_cc1", cycle_cnt, 1);
        chk("t7_ic1", inst_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
